sd_sector_server: RTL and testbench

SD_SECTOR_SERVER -- requirements
Module: sd_sector_server

---
 rtl/sd_pkg.sv | 16 +
 rtl/sd_sector_server.sv | 121 ++++++++++++
 tb/tb_sd_sector_server.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector server: sector geometry and FSM encoding.
package sd_pkg;

  localparam int SECTOR_SIZE = 512;
  localparam int OFFSET_W    = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_PUT  = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_REQ  = 3'd4,
    S_DONE    = 3'd5
  } sd_state_t;

endpackage

// File: rtl/sd_sector_server.sv
// Serves 512-byte sector reads/writes between an SD sector buffer and a byte memory.
// Out-of-range sectors read as zeros and discard writes without touching memory.
module sd_sector_server
  import sd_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  input  logic [63:0]       img_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  sd_state_t           state;
  logic [OFFSET_W-1:0] offset;
  logic                in_range;
  logic                req_in_range;
  logic                last;

  assign req_in_range = (img_size != 64'd0) && (sd_lba < img_size[40:9]);
  assign last         = (offset == OFFSET_W'(SECTOR_SIZE - 1));
  // The buffer address is the offset register itself, so it idles at 0.
  assign sd_buff_addr = offset;

  // Transfer FSM; the upper mem_addr bits hold the captured LBA for the whole sector.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= S_IDLE;
      offset       <= '0;
      in_range     <= 1'b0;
      sd_ack       <= 1'b0;
      sd_buff_wr   <= 1'b0;
      sd_buff_dout <= 8'h00;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 8'h00;
    end else begin
      sd_buff_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sd_rd || sd_wr) begin
            in_range <= req_in_range;
            offset   <= '0;
            sd_ack   <= 1'b1;
            mem_addr <= {sd_lba[ADDR_W-10:0], {OFFSET_W{1'b0}}};
            if (sd_rd) begin
              mem_rd <= req_in_range;
              state  <= S_RD_REQ;
            end else begin
              state  <= S_WR_ADDR;
            end
          end
        end
        S_RD_REQ: begin
          if (!in_range) begin
            sd_buff_dout <= 8'h00;
            sd_buff_wr   <= 1'b1;
            state        <= S_RD_PUT;
          end else if (mem_ready) begin
            mem_rd       <= 1'b0;
            sd_buff_dout <= mem_rdata;
            sd_buff_wr   <= 1'b1;
            state        <= S_RD_PUT;
          end
        end
        S_RD_PUT: begin
          offset                  <= offset + 9'd1;
          mem_addr[OFFSET_W-1:0]  <= offset + 9'd1;
          if (last) begin
            sd_ack <= 1'b0;
            state  <= S_DONE;
          end else begin
            mem_rd <= in_range;
            state  <= S_RD_REQ;
          end
        end
        S_WR_ADDR: begin
          state <= S_WR_REQ;
        end
        S_WR_REQ: begin
          // First WR_REQ cycle latches the buffer byte before raising mem_wr.
          if (in_range && !mem_wr) begin
            mem_wdata <= sd_buff_din;
            mem_wr    <= 1'b1;
          end else if (!in_range || mem_ready) begin
            mem_wr                 <= 1'b0;
            offset                 <= offset + 9'd1;
            mem_addr[OFFSET_W-1:0] <= offset + 9'd1;
            if (last) begin
              sd_ack <= 1'b0;
              state  <= S_DONE;
            end else begin
              state  <= S_WR_ADDR;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_server.sv
// Directed bench for sd_sector_server with a byte-memory responder, a registered
// sector-buffer model and a per-cycle transfer-level checker.
module tb_sd_sector_server;

  localparam int ADDR_W = 25;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       sd_lba = 32'd0;
  logic              sd_rd = 1'b0;
  logic              sd_wr = 1'b0;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din = 8'h00;
  logic [63:0]       img_size = 64'd0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic              mem_ready = 1'b0;

  always #5 clk_sys = ~clk_sys;

  sd_sector_server #(.ADDR_W(ADDR_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_size(img_size),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Backing memory: unwritten bytes read back as the low byte of their address.
  logic [7:0] mem [int unsigned];
  function automatic logic [7:0] mem_byte(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return a[7:0];
  endfunction

  // Sector buffer contents for writes, plus a record of what reads delivered.
  logic [7:0] bufm [0:511];
  logic [7:0] rbuf [0:511];
  always @(posedge clk_sys) sd_buff_din <= bufm[sd_buff_addr];

  // Memory responder: mem_ready after a per-byte latency, evaluated just after each edge.
  int lat_normal = 1;
  int stall_byte = -1;
  int stall_lat  = 7;
  int wait_cnt   = 0;
  always @(posedge clk_sys) begin
    #1;
    if (reset || !(mem_rd || mem_wr) || mem_ready) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (wait_cnt >= ((int'(mem_addr[8:0]) == stall_byte) ? stall_lat : lat_normal)) begin
      mem_ready = 1'b1;
      if (mem_rd) mem_rdata = mem_byte(32'(mem_addr));
      else mem[32'(mem_addr)] = mem_wdata;
    end else begin
      wait_cnt++;
    end
  end

  // Transfer expectations set by the stimulus before each request.
  bit          exp_rd = 1'b0;
  bit          exp_range = 1'b0;
  int unsigned exp_base = 0;
  int          pulse_cnt = 0;
  int          wr_cnt = 0;
  int          rd_cycles = 0;
  int          stall_cnt = 0;
  logic [ADDR_W-1:0] first_mem_addr = '0;

  // Per-cycle checker against the transfer-level model.
  always @(negedge clk_sys) begin
    if (!reset) begin
      chk("rd_wr_exclusive", mem_rd & mem_wr, 1'b0);
      if (!sd_ack) begin
        chk("idle_buff_addr", sd_buff_addr, 9'd0);
        chk("idle_mem_req", mem_rd | mem_wr, 1'b0);
        chk("idle_buff_wr", sd_buff_wr, 1'b0);
      end else if (exp_rd) begin
        chk("read_mem_wr", mem_wr, 1'b0);
        if (!exp_range) chk("oor_mem_rd", mem_rd, 1'b0);
        if (mem_rd) begin
          if (pulse_cnt == 0) first_mem_addr = mem_addr;
          chk("rd_mem_addr", mem_addr, exp_base + pulse_cnt);
          if (pulse_cnt == 100) begin
            rd_cycles++;
            if (!mem_ready) stall_cnt++;
          end
        end
        if (sd_buff_wr) begin
          chk("buff_addr", sd_buff_addr, pulse_cnt);
          chk("buff_dout", sd_buff_dout, exp_range ? mem_byte(exp_base + pulse_cnt) : 8'h00);
          rbuf[sd_buff_addr] = sd_buff_dout;
          pulse_cnt++;
        end
      end else begin
        chk("write_buff_wr", sd_buff_wr, 1'b0);
        chk("write_mem_rd", mem_rd, 1'b0);
        if (!exp_range) chk("oor_mem_wr", mem_wr, 1'b0);
        if (mem_wr) begin
          chk("wr_mem_addr", mem_addr, exp_base + wr_cnt);
          chk("wr_mem_wdata", mem_wdata, bufm[wr_cnt]);
          if (mem_ready) wr_cnt++;
        end
      end
    end
  end

  task automatic xfer(input bit rd, input bit wr, input logic [31:0] lba,
                      input logic [63:0] isz, input bit range, input int abort_at);
    int n;
    exp_rd    = rd;
    exp_range = range;
    exp_base  = lba * 512;
    pulse_cnt = 0;
    wr_cnt    = 0;
    rd_cycles = 0;
    stall_cnt = 0;
    img_size  = isz;
    sd_lba    = lba;
    sd_rd     = rd;
    sd_wr     = wr;
    n = 0;
    while (!sd_ack && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk("ack_rise", sd_ack, 1'b1);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    n = 0;
    while (sd_ack && n < 20000) begin
      if (abort_at >= 0 && int'(sd_buff_addr) == abort_at) begin
        reset = 1'b1;
        @(negedge clk_sys);
        chk("abort_ack", sd_ack, 1'b0);
        chk("abort_mem_wr", mem_wr, 1'b0);
        chk("abort_buff_addr", sd_buff_addr, 9'd0);
        chk("abort_mem_addr", mem_addr, 25'd0);
        reset = 1'b0;
        break;
      end
      @(negedge clk_sys);
      n++;
    end
    chk("ack_fall", sd_ack, 1'b0);
    @(negedge clk_sys);
    if (abort_at < 0) begin
      chk("pulse_count", pulse_cnt, rd ? 512 : 0);
      chk("mem_write_count", wr_cnt, (!rd && range) ? 512 : 0);
    end
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) bufm[i] = 8'hA5 ^ i[7:0];
    repeat (3) @(negedge clk_sys);
    chk("rst_ack", sd_ack, 1'b0);
    chk("rst_buff_wr", sd_buff_wr, 1'b0);
    chk("rst_buff_addr", sd_buff_addr, 9'd0);
    chk("rst_buff_dout", sd_buff_dout, 8'h00);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 25'd0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // In-range read of sector 3 from a 1 MiB image.
    xfer(1'b1, 1'b0, 32'd3, 64'h10_0000, 1'b1, -1);
    chk("r3_first_addr", first_mem_addr, 25'h600);
    chk("r3_byte0", rbuf[0], 8'h00);
    chk("r3_byte255", rbuf[255], 8'hFF);
    chk("r3_byte256", rbuf[256], 8'h00);
    chk("r3_byte511", rbuf[511], 8'hFF);

    // In-range write of sector 2.
    xfer(1'b0, 1'b1, 32'd2, 64'h10_0000, 1'b1, -1);
    chk("w2_mem400", mem_byte(32'h400), 8'hA5);
    chk("w2_mem480", mem_byte(32'h480), 8'h25);
    chk("w2_mem5ff", mem_byte(32'h5FF), 8'h5A);

    // Image of 1024 bytes holds sectors 0..1 only: sector 2 is out of range.
    xfer(1'b1, 1'b0, 32'd2, 64'd1024, 1'b0, -1);
    chk("oor_byte255", rbuf[255], 8'h00);
    chk("oor_byte0", rbuf[0], 8'h00);
    xfer(1'b0, 1'b1, 32'd2, 64'd1024, 1'b0, -1);
    chk("oor_w_mem400", mem_byte(32'h400), 8'hA5);

    // Simultaneous requests resolve to a read; byte 100 stalls for 7 cycles.
    stall_byte = 100;
    xfer(1'b1, 1'b1, 32'd4, 64'h10_0000, 1'b1, -1);
    stall_byte = -1;
    chk("stall_wait_cycles", stall_cnt, 7);
    chk("stall_rd_cycles", rd_cycles, 8);
    chk("r4_byte100", rbuf[100], 8'h64);

    // Reset at byte 200 of a write, then a normal read of the same sector.
    xfer(1'b0, 1'b1, 32'd5, 64'h10_0000, 1'b1, 200);
    chk("abort_byte199_written", mem.exists(32'hA00 + 199), 1'b1);
    chk("abort_byte200_untouched", mem.exists(32'hA00 + 200), 1'b0);
    xfer(1'b1, 1'b0, 32'd5, 64'h10_0000, 1'b1, -1);
    chk("r5_byte199", rbuf[199], 8'h62);
    chk("r5_byte200", rbuf[200], 8'hC8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
